// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search engine.
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PROBE  = 2'd1,
      FINISH = 2'd2,
      SETTLE = 2'd3
   } state_t;

   function automatic int probes_w(input int w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/sar_next.sv
// Next probe point: midpoint of the W+1 bit bounds, truncated to W bits.
module sar_next #(
   parameter int W = 3
) (
   input  logic [W:0]   lo,
   input  logic [W:0]   hi,
   output logic [W-1:0] nxt
);

   assign nxt = W'((lo + hi) >> 1);

endmodule

// File: rtl/sar_search.sv
// Binary-search initiator driving a magnitude comparator.
// Optional CMP_SETTLE_EN inserts a settle cycle ahead of every probe.
module sar_search
   import sar_pkg::*;
#(
   parameter int W = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   cmp_gt,
   input  logic                   cmp_eq,
   input  logic                   cmp_lt,
   output logic [W-1:0]           guess,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic                   err,
   output logic [W-1:0]           result,
   output logic [probes_w(W)-1:0] probes
);

   localparam int PW = probes_w(W);
   localparam logic [W:0]    HMAX = (W+1)'((1 << W) - 1);
   localparam logic [W:0]    ONE  = (W+1)'(1);
   localparam logic [W-1:0]  G0   = W'((1 << (W - 1)) - 1);
   localparam logic [W-1:0]  GMAX = '1;
   localparam logic [W-1:0]  GMIN = '0;
   localparam logic [PW-1:0] P1   = PW'(1);

`ifdef CMP_SETTLE_EN
   localparam state_t LOOP = SETTLE;
`else
   localparam state_t LOOP = PROBE;
`endif

   state_t state;
   logic [W:0] lo, hi;
   logic [W:0] lo_n, hi_n;
   logic [W:0] guess_x;
   logic [W-1:0] nxt;
   logic onehot;
   logic edge_hit;

   assign guess_x = {1'b0, guess};
   assign onehot  = (cmp_gt ^ cmp_eq ^ cmp_lt)
                  & ~(cmp_gt & cmp_eq & cmp_lt);

   // Bounds after applying this probe's outcome.
   always_comb begin
      lo_n = lo;
      hi_n = hi;
      if (cmp_gt) lo_n = guess_x + ONE;
      if (cmp_lt) hi_n = guess_x - ONE;
   end

   assign edge_hit = (cmp_gt && guess == GMAX)
                   || (cmp_lt && guess == GMIN)
                   || (lo_n > hi_n);

   sar_next #(.W(W)) u_next (
      .lo  (lo_n),
      .hi  (hi_n),
      .nxt (nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         guess  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         found  <= 1'b0;
         err    <= 1'b0;
         result <= '0;
         probes <= '0;
         lo     <= '0;
         hi     <= HMAX;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lo     <= '0;
                  hi     <= HMAX;
                  guess  <= G0;
                  probes <= '0;
                  found  <= 1'b0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= LOOP;
               end
            end
            SETTLE: state <= PROBE;
            PROBE: begin
               probes <= probes + P1;
               if (!onehot) begin
                  err   <= 1'b1;
                  found <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FINISH;
               end else if (cmp_eq) begin
                  result <= guess;
                  found  <= 1'b1;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= FINISH;
               end else if (edge_hit) begin
                  found <= 1'b0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= FINISH;
               end else begin
                  lo    <= lo_n;
                  hi    <= hi_n;
                  guess <= nxt;
                  state <= LOOP;
               end
            end
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboarded random/directed bench for sar_search (W=3).
module tb_sar_search;

   localparam int W = 3;

   typedef struct {
      int found;
      int err;
      int result;
      int probes;
      int lat;
      int seq;
   } exp_t;

   logic clk, rst, start;
   logic cmp_gt, cmp_eq, cmp_lt;
   logic [W-1:0] guess, result;
   logic busy, done, found, err;
   logic [2:0] probes;

   int target;
   int mode;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   exp_t q[$];

   sar_search #(.W(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .cmp_gt (cmp_gt),
      .cmp_eq (cmp_eq),
      .cmp_lt (cmp_lt),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .found  (found),
      .err    (err),
      .result (result),
      .probes (probes)
   );

   // Comparator: target on a, guess on b; modes 1/2 force bad flags.
   assign cmp_gt = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0
                 : (target > int'(guess));
   assign cmp_eq = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0
                 : (target == int'(guess));
   assign cmp_lt = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1
                 : (target < int'(guess));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   // Reference: interval halving over integers 0..2^W-1.
   function automatic exp_t model(input int t, input int m);
      exp_t e;
      int lo, hi, g, n, stop;
      lo = 0;
      hi = (1 << W) - 1;
      n = 0;
      stop = 0;
      e.found = 0;
      e.err = 0;
      e.result = -1;
      e.seq = 0;
      while (!stop) begin
         g = (lo + hi) / 2;
         n++;
         e.seq = e.seq * 16 + g;
         if (m == 1) begin
            e.err = 1;
            stop = 1;
         end else if (m == 0 && t == g) begin
            e.found = 1;
            e.result = g;
            stop = 1;
         end else if (m == 0 && t > g) begin
            if (g == (1 << W) - 1) stop = 1;
            else lo = g + 1;
         end else begin
            if (g == 0) stop = 1;
            else hi = g - 1;
         end
         if (!stop && lo > hi) stop = 1;
      end
      e.probes = n;
`ifdef CMP_SETTLE_EN
      e.lat = 2 * n + 1;
`else
      e.lat = n + 1;
`endif
      return e;
   endfunction

   int bprev = 0;
   int t0 = 0;
   int aseq = 0;
   int last = -1;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         bprev = 0;
      end else begin
         if (busy && bprev == 0) begin
            t0 = cyc;
            aseq = 0;
            last = -1;
         end
         if (busy && int'(guess) != last) begin
            aseq = aseq * 16 + int'(guess);
            last = int'(guess);
         end
         if (done) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done: got done=1 want none");
            end else begin
               e = q.pop_front();
               chk("found", int'(found), e.found);
               chk("err", int'(err), e.err);
               chk("probes", int'(probes), e.probes);
               chk("latency", cyc - t0 + 1, e.lat);
               chk("guess_seq", aseq, e.seq);
               chk("busy_at_done", int'(busy), 0);
               if (e.found != 0) chk("result", int'(result), e.result);
            end
         end
         bprev = int'(busy);
      end
   end

   task automatic wait_dones(input int n, input int budget);
      int c = 0;
      int k = 0;
      while (c < n && k < budget) begin
         @(negedge clk);
         k++;
         if (done) c++;
      end
      if (c < n) begin
         total++;
         bad++;
         $display("FAIL timeout: got %0d dones want %0d", c, n);
      end
   endtask

   task automatic run_one(input int t, input int m);
      @(negedge clk);
      target = t;
      mode = m;
      q.push_back(model(t, m));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_dones(1, 40);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      mode = 0;
      target = 0;
      repeat (2) @(negedge clk);
      chk("rst_guess", int'(guess), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_found", int'(found), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_probes", int'(probes), 0);
      rst = 1'b0;

      run_one(5, 0);
      run_one(0, 0);
      run_one(7, 0);
      run_one(2, 1);
      run_one(4, 2);

      // Back-to-back sweep with start held high.
      @(negedge clk);
      mode = 0;
      target = 0;
      for (int i = 0; i < 8; i++) q.push_back(model(i, 0));
      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_dones(1, 40);
         target = i + 1;
         if (i == 7) start = 1'b0;
      end

      for (int i = 0; i < 20; i++)
         run_one(int'($urandom_range(0, 7)), 0);

      // Reset in the middle of a search.
      @(negedge clk);
      target = 6;
      mode = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_guess", int'(guess), 0);
      chk("midrst_done", int'(done), 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run_one(6, 0);

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
